ram_port_arbiter: RTL and testbench

- Two-requester, round-robin arbiter and command sequencer in front of the single-port SPI command RAM. The RAM takes 10-bit command words: opcode din[9:8] plus payload din[7:0].
- Each requester issues whole transactions (write byte or read byte). The block serialises each one into the RAM's two-word command sequence, locks the shared RAM address register for the full transaction, and routes read data back to the issuing requester.
- Sits between the SPI slave front-end (requester 0), the local host/debug port (requester 1) and the RAM.

---
 rtl/ram_port_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Two-requester round-robin arbiter and command sequencer in front of the
// single-port SPI command RAM. Each granted transaction (write byte or read
// byte) becomes the RAM's two-word command sequence:
//   write: {00, addr} then {01, wdata}
//   read : {10, addr} then {11, 00}, followed by a wait for ram_tx_valid
// The RAM is owned by one requester from its grant edge until its done
// pulse, so command words from different requesters never interleave.
//
// Ports
//   CLK, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/req1             level transaction requests, held until granted
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           target address
//   wdata0/wdata1         write data (ignored for reads)
//   gnt0/gnt1             combinational accept; operands latched on that edge
//   done0/done1           registered one-cycle completion pulse
//   rdata0/rdata1         registered read data, held until the next read
//   busy                  high whenever a transaction is in progress
//   ram_din/ram_rx_valid  registered command word and strobe to the RAM
//   ram_dout/ram_tx_valid read data and its strobe from the RAM
//
// DATA_WIDTH must equal ADDR_SIZE and CMD_WIDTH must equal ADDR_SIZE + 2.

module ram_port_arbiter #(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CMD_WIDTH  = 10
) (
    input  logic                  CLK,
    input  logic                  rst_n,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_SIZE-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  done0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_SIZE-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic                  busy,

    output logic [CMD_WIDTH-1:0]  ram_din,
    output logic                  ram_rx_valid,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_tx_valid
);

    // RAM command opcodes carried in the top two bits of the command word.
    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RCAP
    } state_t;

    state_t                  state;
    state_t                  state_next;

    // 1 = requester 1 wins a tie at the next arbitration.
    logic                    prio_one;

    // Operands of the transaction in flight. The address is not kept: it is
    // only needed for the first command word, issued on the grant edge.
    logic                    owner;
    logic                    op_we;
    logic [DATA_WIDTH-1:0]   op_wdata;

    // Operands of whichever requester is granted this cycle.
    logic                    sel_we;
    logic [ADDR_SIZE-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    any_gnt;

    logic [CMD_WIDTH-1:0]    din_next;
    logic                    rxv_next;
    logic                    done0_next;
    logic                    done1_next;
    logic                    rd0_load;
    logic                    rd1_load;

    // ------------------------------------------------------------------
    // Arbitration: only in IDLE. A lone requester always wins; on a tie the
    // requester that was not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (req0 && (!req1 || !prio_one)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? we1    : we0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        din_next   = ram_din;
        rxv_next   = ram_rx_valid;
        done0_next = 1'b0;
        done1_next = 1'b0;
        rd0_load   = 1'b0;
        rd1_load   = 1'b0;

        case (state)
            IDLE: begin
                rxv_next = 1'b0;
                if (any_gnt) begin
                    din_next   = {(sel_we ? OP_WADDR : OP_RADDR), sel_addr};
                    rxv_next   = 1'b1;
                    state_next = ADDR;
                end
            end

            ADDR: begin
                // RAM latches the address on this edge; issue the second word.
                if (op_we) begin
                    din_next = {OP_WDATA, op_wdata};
                end else begin
                    din_next = {OP_RDATA, {ADDR_SIZE{1'b0}}};
                end
                rxv_next   = 1'b1;
                state_next = DATA;
            end

            DATA: begin
                // RAM performs the write, or loads dout, on this edge.
                rxv_next = 1'b0;
                if (op_we) begin
                    done0_next = ~owner;
                    done1_next = owner;
                    state_next = IDLE;
                end else begin
                    state_next = RCAP;
                end
            end

            RCAP: begin
                if (ram_tx_valid) begin
                    rd0_load   = ~owner;
                    rd1_load   = owner;
                    done0_next = ~owner;
                    done1_next = owner;
                    state_next = IDLE;
                end
            end

            default: begin
                rxv_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Command interface, completion pulses and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            prio_one     <= 1'b0;
            owner        <= 1'b0;
            op_we        <= 1'b0;
            op_wdata     <= '0;
        end else begin
            ram_din      <= din_next;
            ram_rx_valid <= rxv_next;
            done0        <= done0_next;
            done1        <= done1_next;
            if (any_gnt) begin
                owner    <= gnt1;
                op_we    <= sel_we;
                op_wdata <= sel_wdata;
                // Hand the tie-break to the requester just passed over.
                prio_one <= gnt0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-requester read data; only the owner's register is updated.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (rd0_load) begin
                rdata0 <= ram_dout;
            end
            if (rd1_load) begin
                rdata1 <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter with a small behavioural model of the
// SPI command RAM (memory clears on rst_n, as the real RAM shares the reset).

module tb_ram_port_arbiter;

    logic       CLK;
    logic       rst_n;
    logic       req0, we0, gnt0, done0;
    logic [7:0] addr0, wdata0, rdata0;
    logic       req1, we1, gnt1, done1;
    logic [7:0] addr1, wdata1, rdata1;
    logic       busy;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    int vectors;
    int miscompares;

    ram_port_arbiter #(
        .ADDR_SIZE (8),
        .DATA_WIDTH(8),
        .CMD_WIDTH (10)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .gnt0        (gnt0),
        .done0       (done0),
        .rdata0      (rdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .gnt1        (gnt1),
        .done1       (done1),
        .rdata1      (rdata1),
        .busy        (busy),
        .ram_din     (ram_din),
        .ram_rx_valid(ram_rx_valid),
        .ram_dout    (ram_dout),
        .ram_tx_valid(ram_tx_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SPI command RAM model
    logic [7:0] mem [256];
    logic [7:0] ram_waddr, ram_raddr;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            ram_waddr    <= 8'h00;
            ram_raddr    <= 8'h00;
            ram_dout     <= 8'h00;
            ram_tx_valid <= 1'b0;
        end else begin
            ram_tx_valid <= 1'b0;
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00: ram_waddr <= ram_din[7:0];
                    2'b01: mem[ram_waddr] <= ram_din[7:0];
                    2'b10: ram_raddr <= ram_din[7:0];
                    default: begin
                        ram_dout     <= mem[ram_raddr];
                        ram_tx_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Stimulus helper: runs one transaction with fixed latency and returns
    // what it observed; callers compare against their own expectations.
    task automatic do_txn(input logic who, input logic we, input logic [7:0] a,
                          input logic [7:0] d, output logic g,
                          output logic [9:0] w1, output logic [9:0] w2,
                          output logic dn, output logic [7:0] rd);
        @(negedge CLK);
        if (!who) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else      begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        #1 g = who ? gnt1 : gnt0;
        @(negedge CLK);
        req0 = 1'b0; req1 = 1'b0;
        w1 = ram_din;
        @(negedge CLK);
        w2 = ram_din;
        @(negedge CLK);
        if (!we) @(negedge CLK);
        dn = who ? done1 : done0;
        rd = who ? rdata1 : rdata0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        #2;
        vectors++; if (ram_din !== 10'h000) begin miscompares++; $display("FAIL reset_din: got %h want 000", ram_din); end
        vectors++; if (ram_rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rxv: got %b want 0", ram_rx_valid); end
        vectors++; if ({busy, done0, done1} !== 3'b000) begin miscompares++; $display("FAIL reset_ctl: busy/done0/done1 got %b want 000", {busy, done0, done1}); end
        vectors++; if ({rdata0, rdata1} !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata: got %h want 0000", {rdata0, rdata1}); end
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_write_first();
        @(negedge CLK);
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'hA5;
        #1;
        vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL w_gnt: got %b want 10", {gnt0, gnt1}); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL w_busy_idle: got %b want 0", busy); end
        @(negedge CLK);
        req0 = 0;
        vectors++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h005}) begin miscompares++; $display("FAIL w_word1: got %b/%h want 1/005", ram_rx_valid, ram_din); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL w_busy_addr: got %b want 1", busy); end
        @(negedge CLK);
        vectors++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h1A5}) begin miscompares++; $display("FAIL w_word2: got %b/%h want 1/1a5", ram_rx_valid, ram_din); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL w_busy_data: got %b want 1", busy); end
        @(negedge CLK);
        vectors++; if ({ram_rx_valid, done0, done1} !== 3'b010) begin miscompares++; $display("FAIL w_done: rxv/done0/done1 got %b want 010", {ram_rx_valid, done0, done1}); end
        @(negedge CLK);
        vectors++; if ({done0, busy} !== 2'b00) begin miscompares++; $display("FAIL w_done_pulse: done0/busy got %b want 00", {done0, busy}); end
    endtask

    task automatic test_read_back();
        @(negedge CLK);
        req1 = 1; we1 = 0; addr1 = 8'h05; wdata1 = 8'hFF;
        #1;
        vectors++; if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL r_gnt: got %b want 01", {gnt0, gnt1}); end
        @(negedge CLK);
        req1 = 0;
        vectors++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h205}) begin miscompares++; $display("FAIL r_word1: got %b/%h want 1/205", ram_rx_valid, ram_din); end
        @(negedge CLK);
        vectors++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h300}) begin miscompares++; $display("FAIL r_word2: got %b/%h want 1/300", ram_rx_valid, ram_din); end
        @(negedge CLK);
        vectors++; if ({ram_rx_valid, done1, busy} !== 3'b001) begin miscompares++; $display("FAIL r_rcap: rxv/done1/busy got %b want 001", {ram_rx_valid, done1, busy}); end
        @(negedge CLK);
        vectors++; if ({done0, done1} !== 2'b01) begin miscompares++; $display("FAIL r_done: got %b want 01", {done0, done1}); end
        vectors++; if (rdata1 !== 8'hA5) begin miscompares++; $display("FAIL r_rdata1: got %h want a5", rdata1); end
        vectors++; if (rdata0 !== 8'h00) begin miscompares++; $display("FAIL r_rdata0_kept: got %h want 00", rdata0); end
    endtask

    task automatic test_alternate();
        logic own;
        @(negedge CLK);
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h22;
        for (int g = 0; g < 4; g++) begin
            own = (g % 2) == 1;
            #1;
            vectors++; if ({gnt0, gnt1} !== {!own, own}) begin miscompares++; $display("FAIL alt_gnt[%0d]: got %b want %b", g, {gnt0, gnt1}, {!own, own}); end
            @(negedge CLK);
            vectors++; if (ram_din !== (own ? 10'h020 : 10'h010)) begin miscompares++; $display("FAIL alt_word1[%0d]: got %h want %h", g, ram_din, own ? 10'h020 : 10'h010); end
            vectors++; if ({gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL alt_nogrant[%0d]: got %b want 00", g, {gnt0, gnt1}); end
            @(negedge CLK);
            vectors++; if (ram_din !== (own ? 10'h122 : 10'h111)) begin miscompares++; $display("FAIL alt_word2[%0d]: got %h want %h", g, ram_din, own ? 10'h122 : 10'h111); end
            @(negedge CLK);
            vectors++; if ({done0, done1} !== {!own, own}) begin miscompares++; $display("FAIL alt_done[%0d]: got %b want %b", g, {done0, done1}, {!own, own}); end
        end
        req0 = 0; req1 = 0;
        @(negedge CLK);
        vectors++; if (ram_rx_valid !== 1'b0) begin miscompares++; $display("FAIL alt_idle_rxv: got %b want 0", ram_rx_valid); end
    endtask

    task automatic test_wait_mid();
        @(negedge CLK);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        #1;
        vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL wt_gnt0: got %b want 1", gnt0); end
        @(negedge CLK);
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'h33;
        #1;
        vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL wt_gnt1_addr: got %b want 0", gnt1); end
        @(negedge CLK);
        addr1 = 8'h31; wdata1 = 8'h34;
        #1;
        vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL wt_gnt1_data: got %b want 0", gnt1); end
        @(negedge CLK);
        #1;
        vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL wt_gnt1_rcap: got %b want 0", gnt1); end
        @(negedge CLK);
        #1;
        vectors++; if ({done0, rdata0} !== {1'b1, 8'h11}) begin miscompares++; $display("FAIL wt_done0: done0/rdata0 got %b/%h want 1/11", done0, rdata0); end
        vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL wt_gnt1_idle: got %b want 1", gnt1); end
        @(negedge CLK);
        req1 = 0; addr1 = 8'h32; wdata1 = 8'h35;
        vectors++; if (ram_din !== 10'h031) begin miscompares++; $display("FAIL wt_word1: got %h want 031", ram_din); end
        @(negedge CLK);
        vectors++; if (ram_din !== 10'h134) begin miscompares++; $display("FAIL wt_word2: got %h want 134", ram_din); end
        @(negedge CLK);
        vectors++; if ({done0, done1} !== 2'b01) begin miscompares++; $display("FAIL wt_done1: got %b want 01", {done0, done1}); end
    endtask

    task automatic test_reset_mid();
        logic       g, dn;
        logic [9:0] w1, w2;
        logic [7:0] rd;
        @(negedge CLK);
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'h77;
        @(negedge CLK);
        req0 = 0;
        @(negedge CLK);
        vectors++; if ({busy, ram_din} !== {1'b1, 10'h177}) begin miscompares++; $display("FAIL rm_in_data: busy/din got %b/%h want 1/177", busy, ram_din); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({busy, ram_rx_valid, done0, done1, ram_din} !== 14'h0) begin miscompares++; $display("FAIL rm_async: busy/rxv/done0/done1/din got %b want all 0", {busy, ram_rx_valid, done0, done1, ram_din}); end
        vectors++; if ({rdata0, rdata1} !== 16'h0000) begin miscompares++; $display("FAIL rm_rdata: got %h want 0000", {rdata0, rdata1}); end
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        vectors++; if ({done0, done1} !== 2'b00) begin miscompares++; $display("FAIL rm_no_done: got %b want 00", {done0, done1}); end
        do_txn(1'b0, 1'b0, 8'h05, 8'h00, g, w1, w2, dn, rd);
        vectors++; if ({g, dn, w1, w2} !== {2'b11, 10'h205, 10'h300}) begin miscompares++; $display("FAIL rm_read: gnt/done/w1/w2 got %b/%b/%h/%h want 1/1/205/300", g, dn, w1, w2); end
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL rm_rdata0: got %h want 00", rd); end
    endtask

    task automatic test_boundaries();
        logic       g, dn;
        logic [9:0] w1, w2;
        logic [7:0] rd;
        do_txn(1'b1, 1'b1, 8'h00, 8'h3C, g, w1, w2, dn, rd);
        vectors++; if ({g, dn, w1, w2} !== {2'b11, 10'h000, 10'h13C}) begin miscompares++; $display("FAIL bd_wr00: gnt/done/w1/w2 got %b/%b/%h/%h want 1/1/000/13c", g, dn, w1, w2); end
        do_txn(1'b0, 1'b1, 8'hFF, 8'hC3, g, w1, w2, dn, rd);
        vectors++; if ({g, dn, w1, w2} !== {2'b11, 10'h0FF, 10'h1C3}) begin miscompares++; $display("FAIL bd_wrff: gnt/done/w1/w2 got %b/%b/%h/%h want 1/1/0ff/1c3", g, dn, w1, w2); end
        do_txn(1'b0, 1'b0, 8'h00, 8'h00, g, w1, w2, dn, rd);
        vectors++; if ({g, dn, w1, w2, rd} !== {2'b11, 10'h200, 10'h300, 8'h3C}) begin miscompares++; $display("FAIL bd_rd00: gnt/done/w1/w2/rdata got %b/%b/%h/%h/%h want 1/1/200/300/3c", g, dn, w1, w2, rd); end
        do_txn(1'b1, 1'b0, 8'hFF, 8'h00, g, w1, w2, dn, rd);
        vectors++; if ({g, dn, w1, w2, rd} !== {2'b11, 10'h2FF, 10'h300, 8'hC3}) begin miscompares++; $display("FAIL bd_rdff: gnt/done/w1/w2/rdata got %b/%b/%h/%h/%h want 1/1/2ff/300/c3", g, dn, w1, w2, rd); end
        vectors++; if (rdata0 !== 8'h3C) begin miscompares++; $display("FAIL bd_rdata0_kept: got %h want 3c", rdata0); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_first();
        test_read_back();
        test_alternate();
        test_wait_mid();
        test_reset_mid();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
